rsa_modexp_decoder: RTL and testbench
=====================================

// Module: rsa_modexp_decoder
// PURPOSE
//  Sequential RSA decryption engine: computes m = c^d mod n by right-to-left
//  square-and-multiply with bit-serial shift-subtract modular reduction.
//  Sits on the decoder side of the 4-bit RSA datapath, opposite the encoder.
//  Output m feeds the 8-bit equality comparator for round-trip plaintext check.
// PARAMETERS
//  WIDTH  8  width of c, d, n, m; products are 2*WIDTH, remainder is WIDTH+1
// PORTS
//  clk      in   1      rising-edge clock, single clock domain
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request; sampled only in IDLE
//  c        in   WIDTH  ciphertext; latched on accepted start
//  d        in   WIDTH  private exponent; latched on accepted start
//  n        in   WIDTH  modulus; latched on accepted start; must be >= 2
//  m        out  WIDTH  plaintext result; registered, held until next accepted start
//  busy     out  1      high from cycle after accept through the DONE cycle
//  done     out  1      one-cycle pulse, m valid in same cycle
//  err      out  1      one-cycle pulse, start with n < 2 rejected
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; m=0, busy=0, done=0, err=0, internals 0.
//  Reset mid-operation aborts the job, with no done. First start after release is accepted normally.
//  States: IDLE, RED, LOOP, MULR, MULB, DONE.
//  IDLE: start & n>=2 -> latch c,d,n; res=1; exp=d; go RED. m is cleared to 0.
//        start & n<2  -> err=1 next cycle, stay IDLE, busy stays 0, m unchanged.
//  RED (WIDTH cycles): base = c mod n, bit-serial, MSB first. Handles c >= n.
//  LOOP (1 cycle): exp==0 -> DONE; exp[0]=1 -> MULR; else -> MULB.
//  MULR (2*WIDTH cycles): res = (res*base) mod n; then MULB.
//  MULB (2*WIDTH cycles): base = (base*base) mod n; exp >>= 1; then LOOP.
//  DONE (1 cycle): m=res, done=1, busy=1. Next state is IDLE; busy drops the following cycle.
//  Reduction step, per product bit i = 2W-1..0:
//    r = {r,P[i]}; if r >= n then r = r - n.
//    r is WIDTH+1 bits, unsigned, and never exceeds 2n-1.
//  Product P is full 2*WIDTH unsigned. No truncation before reduction.
//  Latency, accepted start at cycle T, L = bit length of d, P = popcount(d):
//    done at T + 2 + WIDTH + L*(2*WIDTH+1) + 2*WIDTH*P.
//    For WIDTH=8 this is T+10+17L+16P.
//  d=0 -> m=1, done at T+WIDTH+2.
//  start while busy is ignored; c/d/n changes while busy have no effect.
//  start in the DONE cycle is ignored. Accept only from IDLE.
//  done and err are never asserted together. busy is never 1 while err is 1.
// TESTING
//  1 n=33,c=31,d=7 at T -> done=1, m=4 at T+109, busy 1 for T+1..T+109, done pulse 1 cycle.
//  2 n=33,c=5,d=0 -> m=1, done at T+10.
//    c=40,n=33,d=1 -> m=7, done at T+43 (exercises c>=n reduction).
//  3 n=255,c=254,d=2 -> m=1, done at T+60 (max operands, 9-bit remainder path).
//    n=1 or n=0 with start -> err=1 at T+1 only; busy=0, done=0, m unchanged.
//  4 Start accepted, then start again at T+5 with different c/d/n -> ignored.
//    Original result delivered on schedule.
//  5 rst_n low at T+20 mid-job -> outputs 0 immediately, no done.
//    After release, case 1 repeated -> same m and latency.
//  6 Random sweep, n in 2..255, c,d in 0..255: m == c^d mod n from the reference model,
//    latency per formula. Feed m and the expected value into the equality comparator, e=1.

Source files
------------

// File: rtl/rsa_modexp_decoder.sv
// rsa_modexp_decoder: m = c^d mod n by right-to-left square-and-multiply
// with bit-serial shift-subtract reduction of each full-width product.
module rsa_modexp_decoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] m,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int CW = $clog2(2*WIDTH);
   typedef enum logic [2:0] {IDLE, RED, LOOP, MULR, MULB, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] nq, base, res, ex;
   logic [2*WIDTH-1:0] sh;
   logic [WIDTH:0] r, r_sh, r_nx;
   logic [CW-1:0] cnt;
   logic last, accept, shifting;
   assign accept = state == IDLE && start && n >= WIDTH'(2);
   assign shifting = state == RED || state == MULR || state == MULB;
   assign last = state == RED ? cnt == CW'(WIDTH-1) : cnt == CW'(2*WIDTH-1);
   // r stays below n between steps, so the shifted value is at most 2n-1
   assign r_sh = {r[WIDTH-1:0], sh[2*WIDTH-1]};
   assign r_nx = r_sh >= {1'b0, nq} ? r_sh - {1'b0, nq} : r_sh;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? RED : IDLE;
         RED:     state_nx = last ? LOOP : RED;
         LOOP:    state_nx = ex == '0 ? DONE : ex[0] ? MULR : MULB;
         MULR:    state_nx = last ? MULB : MULR;
         MULB:    state_nx = last ? LOOP : MULB;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m <= '0;
         err <= 1'b0;
         nq <= '0;
         base <= '0;
         res <= '0;
         ex <= '0;
         sh <= '0;
         r <= '0;
         cnt <= '0;
      end else begin
         err <= state == IDLE && start && n < WIDTH'(2);
         cnt <= shifting && !last ? cnt + CW'(1) : '0;
         r <= shifting && !last ? r_nx : '0;
         case (state)
            IDLE: if (accept) begin
               nq <= n;
               ex <= d;
               res <= WIDTH'(1);
               m <= '0;
               sh <= {c, WIDTH'(0)};
            end
            RED: begin
               sh <= sh << 1;
               if (last) base <= r_nx[WIDTH-1:0];
            end
            LOOP:
               if (ex == '0) m <= res;
               else sh <= ex[0] ? res * base : base * base;
            MULR: begin
               sh <= last ? base * base : sh << 1;
               if (last) res <= r_nx[WIDTH-1:0];
            end
            MULB: begin
               sh <= sh << 1;
               if (last) begin
                  base <= r_nx[WIDTH-1:0];
                  ex <= ex >> 1;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_rsa_modexp_decoder.sv
// tb_rsa_modexp_decoder: directed and random jobs checked every cycle against
// a plain-arithmetic model of result value and output timeline.
module tb_rsa_modexp_decoder;
   localparam int W = 8;
   logic clk = 0, rst_n = 0, start = 0;
   logic [W-1:0] c = 0, d = 0, n = 0, m;
   logic busy, done, err;
   int tests = 0, fails = 0, cyc = 0;
   int t_acc = -1000, t_done = -2000, t_err = -1000, want = 0, exp_m = 0;
   rsa_modexp_decoder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .c(c), .d(d), .n(n),
      .m(m), .busy(busy), .done(done), .err(err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic int modexp(int cc, int dd, int nn);
      int v = 1 % nn;
      for (int i = 0; i < dd; i++) v = (v * cc) % nn;
      return v;
   endfunction
   function automatic int lat(int dd);
      return 2 + W + $clog2(dd + 1) * (2*W + 1) + 2*W*$countones(dd);
   endfunction
   task automatic chk(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endtask
   // expected timeline: busy T+1..done, done pulse, err pulse, held m
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_m", m, 0);
      end else begin
         if (cyc == t_acc + 1) exp_m = 0;
         if (cyc == t_done) exp_m = want;
         chk("busy", busy, int'(cyc >= t_acc + 1 && cyc <= t_done));
         chk("done", done, int'(cyc == t_done));
         chk("err", err, int'(cyc == t_err));
         chk("m", m, exp_m);
         if (done && busy && err) chk("done_err_busy_excl", 1, 0);
      end
   end
   task automatic wait_cyc(int k);
      for (int i = 0; i < 3000 && cyc < k; i++) @(negedge clk);
      if (cyc < k) chk("wait_timeout", cyc, k);
   endtask
   task automatic drive(int cc, int dd, int nn, bit model);
      @(negedge clk); #2;
      c = W'(cc); d = W'(dd); n = W'(nn); start = 1;
      if (model) begin
         if (nn < 2) t_err = cyc + 1;
         else begin
            t_acc = cyc;
            t_done = cyc + lat(dd);
            want = modexp(cc, dd, nn);
         end
      end
      @(negedge clk); #2;
      start = 0;
   endtask
   task automatic job(int cc, int dd, int nn);
      drive(cc, dd, nn, 1);
      wait_cyc(t_done + 2);
   endtask
   initial begin
      chk("model_31_7_33", modexp(31, 7, 33), 4);
      chk("model_5_0_33", modexp(5, 0, 33), 1);
      chk("model_40_1_33", modexp(40, 1, 33), 7);
      chk("model_254_2_255", modexp(254, 2, 255), 1);
      chk("lat_d7", lat(7), 109);
      chk("lat_d0", lat(0), 10);
      chk("lat_d1", lat(1), 43);
      chk("lat_d2", lat(2), 60);
      repeat (3) @(negedge clk);
      #2 rst_n = 1;
      job(31, 7, 33);
      job(5, 0, 33);
      job(40, 1, 33);
      job(254, 2, 255);
      drive(9, 3, 1, 1);
      wait_cyc(cyc + 3);
      drive(9, 3, 0, 1);
      wait_cyc(cyc + 3);
      drive(31, 7, 33, 1);
      wait_cyc(t_acc + 5);
      #2 start = 1; c = 40; d = 1; n = 33;
      @(negedge clk); #2 start = 0; d = 255; n = 0;
      wait_cyc(t_done);
      #2 start = 1;
      @(negedge clk); #2 start = 0;
      wait_cyc(t_done + 4);
      drive(31, 7, 33, 1);
      wait_cyc(t_acc + 20);
      #2 rst_n = 0;
      t_acc = -1000; t_done = -2000; t_err = -1000; exp_m = 0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_m", m, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1;
      job(31, 7, 33);
      for (int i = 0; i < 20; i++)
         job($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(2, 255));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
